// File: rtl/narrow_32to16_unit.sv
// narrow_32to16_unit: narrows 32-bit words to 16 bits with range check, clamp/truncate, overflow counter and 2-entry FIFO
module narrow_32to16_unit #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_ovf,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ovf_count
);
  logic [1:0][15:0] mem_data;
  logic [1:0]       mem_ovf;
  logic             wr_ptr, rd_ptr, rdy_q;
  logic [1:0]       count;
  logic             ovf, push, pop;
  logic [15:0]      res, sat_val;
  always_comb begin
    ovf     = in_signed ? !((&in_data[31:15]) || !(|in_data[31:15])) : |in_data[31:16];
    sat_val = in_signed ? (in_data[31] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
    res     = (ovf && in_sat) ? sat_val : in_data[15:0];
    in_ready  = rdy_q && (count < 2'd2);
    out_valid = count != 2'd0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    out_data  = mem_data[rd_ptr];
    out_ovf   = mem_ovf[rd_ptr];
  end
  // rdy_q holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_data  <= '0;
      mem_ovf   <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      rdy_q     <= 1'b0;
      ovf_count <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (push) begin
        mem_data[wr_ptr] <= res;
        mem_ovf[wr_ptr]  <= ovf;
        wr_ptr           <= !wr_ptr;
      end
      if (pop) rd_ptr <= !rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (cnt_clr) ovf_count <= '0;
      else if (push && ovf && !(&ovf_count)) ovf_count <= ovf_count + 1'b1;
    end
  end
endmodule
